// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - data-hazard forwarding select and load-use stall generation
//
// Purpose:
//   Produces per-source operand-forwarding selects for the EX stage and a
//   stall request for the ID stage. The stall request covers three cases:
//   a load in EX that an ID source depends on, older loads still in flight
//   (tracked in a short delay line when loads need more than one bubble),
//   and, when forwarding is disabled, any RAW dependency on EX or MEM.
//   A saturating counter accumulates the number of stalled cycles.
//
// Parameters:
//   REG_AW   - register address width
//   NUM_SRC  - source operands per instruction (1..4)
//   LOAD_LAT - load-use bubbles required (1..4)
//   FWD_EN   - 1 = full forwarding, 0 = stall-only
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   id_rs, id_rs_used  - ID-stage source addresses / read enables
//   ex_rs              - ID/EX source addresses (forwarding compare)
//   id_ex_*            - destination info of the instruction in EX
//   ex_mem_*, mem_wb_* - destination info of the instructions in MEM / WB
//   flush, hold        - pipeline flush / global freeze
//   forward            - per-source select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall              - hold PC and IF/ID, bubble into ID/EX
//   stall_cycles       - saturating stalled-cycle count

module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [REG_AW-1:0]           id_ex_rd,
  input  logic                        id_ex_RegWrite,
  input  logic                        id_ex_MemRead,
  input  logic [REG_AW-1:0]           ex_mem_rd,
  input  logic                        ex_mem_RegWrite,
  input  logic [REG_AW-1:0]           mem_wb_rd,
  input  logic                        mem_wb_RegWrite,
  input  logic                        flush,
  input  logic                        hold,
  output logic [2*NUM_SRC-1:0]        forward,
  output logic                        stall,
  output logic [15:0]                 stall_cycles
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic [NUM_SRC-1:0] live;
  logic               load_in_ex;
  logic               load_hz;
  logic               dly_hz;
  logic               raw_hz;
  logic               advance;

  // A source only matters if it is actually read and is not the hardwired x0.
  always_comb begin
    live = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      live[i] = id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] != '0);
    end
  end

  assign load_in_ex = id_ex_MemRead && id_ex_RegWrite && (id_ex_rd != '0);

  always_comb begin
    load_hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (load_in_ex && live[i] && (id_rs[i*REG_AW +: REG_AW] == id_ex_rd)) begin
        load_hz = 1'b1;
      end
    end
  end

  // Forwarding selects; EX/MEM wins over MEM/WB because it holds the younger value.
  generate
    if (FWD_EN != 0) begin : g_fwd
      always_comb begin
        forward = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (ex_mem_RegWrite && (ex_mem_rd != '0) &&
              (ex_mem_rd == ex_rs[i*REG_AW +: REG_AW])) begin
            forward[2*i +: 2] = FWD_MEM;
          end else if (mem_wb_RegWrite && (mem_wb_rd != '0) &&
                       (mem_wb_rd == ex_rs[i*REG_AW +: REG_AW])) begin
            forward[2*i +: 2] = FWD_WB;
          end else begin
            forward[2*i +: 2] = FWD_RF;
          end
        end
      end
    end else begin : g_nofwd
      assign forward = '0;
    end
  endgenerate

  // Without forwarding every in-flight producer in EX or MEM blocks the
  // reader; WB is safe because the register file writes before it reads.
  // A live source is never x0, so no separate rd!=0 qualifier is needed.
  generate
    if (FWD_EN == 0) begin : g_raw
      always_comb begin
        raw_hz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (live[i] &&
              ((id_ex_RegWrite  && (id_rs[i*REG_AW +: REG_AW] == id_ex_rd)) ||
               (ex_mem_RegWrite && (id_rs[i*REG_AW +: REG_AW] == ex_mem_rd)))) begin
            raw_hz = 1'b1;
          end
        end
      end
    end else begin : g_noraw
      assign raw_hz = 1'b0;
    end
  endgenerate

  // flush and hold only decide what happens at the edge, never the current stall.
  assign advance = !flush && !hold;

  // Delay line for loads needing more than one bubble. Entry k holds the
  // load that left EX k+1 advancing edges ago; each load keeps its own slot.
  generate
    if (LOAD_LAT > 1) begin : g_dly
      localparam int DEPTH = LOAD_LAT - 1;

      logic [DEPTH-1:0]  dl_valid;
      logic [REG_AW-1:0] dl_rd [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          dl_valid <= '0;
          for (int k = 0; k < DEPTH; k++) begin
            dl_rd[k] <= '0;
          end
        end else if (flush) begin
          // Also discards the load presently in EX: entry 0 captures nothing.
          dl_valid <= '0;
        end else if (!hold) begin
          dl_valid[0] <= load_in_ex;
          dl_rd[0]    <= id_ex_rd;
          for (int k = 1; k < DEPTH; k++) begin
            dl_valid[k] <= dl_valid[k-1];
            dl_rd[k]    <= dl_rd[k-1];
          end
        end
      end

      always_comb begin
        dly_hz = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (dl_valid[k] && live[i] && (dl_rd[k] == id_rs[i*REG_AW +: REG_AW])) begin
              dly_hz = 1'b1;
            end
          end
        end
      end
    end else begin : g_nodly
      assign dly_hz = 1'b0;
    end
  endgenerate

  assign stall = !rst && (load_hz || dly_hz || raw_hz);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (advance && stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [9:0]  ex_rs;
  logic [4:0]  id_ex_rd;
  logic        id_ex_RegWrite;
  logic        id_ex_MemRead;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_RegWrite;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_RegWrite;
  logic        flush;
  logic        hold;

  // instance 0: LOAD_LAT=1 FWD_EN=1, 1: LOAD_LAT=3 FWD_EN=1, 2: LOAD_LAT=1 FWD_EN=0
  logic [3:0]  fwd_o   [3];
  logic        stall_o [3];
  logic [15:0] cnt_o   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .FWD_EN(1)) u_l1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
    .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_RegWrite(mem_wb_RegWrite),
    .flush(flush), .hold(hold),
    .forward(fwd_o[0]), .stall(stall_o[0]), .stall_cycles(cnt_o[0]));

  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .FWD_EN(1)) u_l3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
    .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_RegWrite(mem_wb_RegWrite),
    .flush(flush), .hold(hold),
    .forward(fwd_o[1]), .stall(stall_o[1]), .stall_cycles(cnt_o[1]));

  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
    .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_RegWrite(mem_wb_RegWrite),
    .flush(flush), .hold(hold),
    .forward(fwd_o[2]), .stall(stall_o[2]), .stall_cycles(cnt_o[2]));

  // ---------------- reference model ----------------
  // past_load[n][k]: register loaded by the instruction that left EX k+1
  // advancing edges ago (0 = no load). count[n]: stalled advancing edges.
  int past_load [3][4];
  int count     [3];

  function automatic int lat_of(input int n);
    return (n == 1) ? 3 : 1;
  endfunction

  function automatic bit fwd_en_of(input int n);
    return (n != 2);
  endfunction

  function automatic bit model_stall(input int n);
    bit hit = 0;
    int s;
    if (rst) return 0;
    for (int i = 0; i < 2; i++) begin
      s = int'(id_rs[i*5 +: 5]);
      if (id_rs_used[i] && s != 0) begin
        if (id_ex_MemRead && id_ex_RegWrite && s == int'(id_ex_rd)) hit = 1;
        for (int k = 0; k < lat_of(n) - 1; k++)
          if (past_load[n][k] == s) hit = 1;
        if (!fwd_en_of(n)) begin
          if (id_ex_RegWrite && s == int'(id_ex_rd)) hit = 1;
          if (ex_mem_RegWrite && s == int'(ex_mem_rd)) hit = 1;
        end
      end
    end
    return hit;
  endfunction

  function automatic logic [3:0] model_fwd(input int n);
    logic [3:0] f = 4'b0000;
    int s;
    if (!fwd_en_of(n)) return 4'b0000;
    for (int i = 0; i < 2; i++) begin
      s = int'(ex_rs[i*5 +: 5]);
      if (ex_mem_RegWrite && ex_mem_rd != 0 && s == int'(ex_mem_rd))
        f[2*i +: 2] = 2'b10;
      else if (mem_wb_RegWrite && mem_wb_rd != 0 && s == int'(mem_wb_rd))
        f[2*i +: 2] = 2'b01;
    end
    return f;
  endfunction

  initial begin
    for (int n = 0; n < 3; n++) begin
      count[n] = 0;
      for (int k = 0; k < 4; k++) past_load[n][k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (rst) begin
        count[n] = 0;
        for (int k = 0; k < 4; k++) past_load[n][k] = 0;
      end else if (flush) begin
        for (int k = 0; k < 4; k++) past_load[n][k] = 0;
      end else if (!hold) begin
        if (model_stall(n) && count[n] < 65535) count[n] = count[n] + 1;
        for (int k = 3; k > 0; k--) past_load[n][k] = past_load[n][k-1];
        past_load[n][0] = (id_ex_MemRead && id_ex_RegWrite) ? int'(id_ex_rd) : 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      checks = checks + 3;
      if (stall_o[n] !== model_stall(n)) begin
        errors = errors + 1;
        $display("FAIL cmp_stall inst%0d t=%0t got %0b exp %0b", n, $time, stall_o[n], model_stall(n));
      end
      if (fwd_o[n] !== model_fwd(n)) begin
        errors = errors + 1;
        $display("FAIL cmp_forward inst%0d t=%0t got %b exp %b", n, $time, fwd_o[n], model_fwd(n));
      end
      if (cnt_o[n] !== 16'(count[n])) begin
        errors = errors + 1;
        $display("FAIL cmp_count inst%0d t=%0t got %0d exp %0d", n, $time, cnt_o[n], count[n]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; hold = 0;
    id_rs = '0; id_rs_used = '0; ex_rs = '0;
    id_ex_rd = '0; id_ex_RegWrite = 0; id_ex_MemRead = 0;
    ex_mem_rd = '0; ex_mem_RegWrite = 0; mem_wb_rd = '0; mem_wb_RegWrite = 0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    id_ex_rd = rd; id_ex_RegWrite = 1; id_ex_MemRead = 1;
  endtask

  task automatic ex_bubble();
    id_ex_rd = '0; id_ex_RegWrite = 0; id_ex_MemRead = 0;
  endtask

  task automatic id_read0(input logic [4:0] r);
    id_rs = {5'd0, r}; id_rs_used = 2'b01;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    rst = 1;
    // reset: stall forced low, forwarding still combinational
    ex_load(5'd7); id_read0(5'd7);
    ex_mem_rd = 5'd5; ex_mem_RegWrite = 1; ex_rs = {5'd0, 5'd5};
    cyc(); cyc(); settle();
    chk("rst_stall_l1", 32'(stall_o[0]), 32'd0);
    chk("rst_stall_l3", 32'(stall_o[1]), 32'd0);
    chk("rst_count_l3", 32'(cnt_o[1]), 32'd0);
    chk("rst_forward_l1", 32'(fwd_o[0]), 32'h2);

    // forwarding priority and encodings
    idle();
    ex_mem_rd = 5'd5; ex_mem_RegWrite = 1; mem_wb_rd = 5'd5; mem_wb_RegWrite = 1;
    ex_rs = {5'd0, 5'd5}; settle();
    chk("fwd_exmem_prio", 32'(fwd_o[0]), 32'h2);
    chk("fwd_disabled", 32'(fwd_o[2]), 32'h0);
    cyc(); ex_mem_RegWrite = 0; settle();
    chk("fwd_memwb", 32'(fwd_o[0]), 32'h1);
    cyc(); ex_mem_RegWrite = 1; mem_wb_rd = 5'd6; ex_rs = {5'd6, 5'd5}; settle();
    chk("fwd_mixed", 32'(fwd_o[1]), 32'h6);
    cyc(); ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; ex_rs = '0; settle();
    chk("fwd_x0", 32'(fwd_o[0]), 32'h0);
    cyc();

    // LOAD_LAT=1: single bubble
    do_reset();
    ex_load(5'd7); id_read0(5'd7); settle();
    chk("l1_stall_a", 32'(stall_o[0]), 32'd1);
    cyc(); ex_bubble(); settle();
    chk("l1_stall_b", 32'(stall_o[0]), 32'd0);
    chk("l1_count", 32'(cnt_o[0]), 32'd1);
    cyc();

    // LOAD_LAT=3: three stalled cycles
    do_reset();
    ex_load(5'd9); id_read0(5'd9); settle();
    chk("l3_stall_0", 32'(stall_o[1]), 32'd1);
    cyc(); ex_bubble(); settle();
    chk("l3_stall_1", 32'(stall_o[1]), 32'd1);
    cyc(); settle();
    chk("l3_stall_2", 32'(stall_o[1]), 32'd1);
    cyc(); settle();
    chk("l3_stall_3", 32'(stall_o[1]), 32'd0);
    chk("l3_count", 32'(cnt_o[1]), 32'd3);
    cyc();

    // back-to-back loads keep separate entries
    do_reset();
    ex_load(5'd4); id_read0(5'd1); settle();
    chk("b2b_a", 32'(stall_o[1]), 32'd0);
    cyc(); ex_load(5'd6); id_read0(5'd2); settle();
    chk("b2b_b", 32'(stall_o[1]), 32'd0);
    cyc(); ex_bubble(); id_read0(5'd4); settle();
    chk("b2b_x4_entry1", 32'(stall_o[1]), 32'd1);
    cyc(); id_read0(5'd6); settle();
    chk("b2b_x6_kept", 32'(stall_o[1]), 32'd1);
    cyc();

    // flush drops the load in EX; stall itself ignores flush
    do_reset();
    ex_load(5'd9); id_read0(5'd9); flush = 1; settle();
    chk("flush_same_cycle", 32'(stall_o[1]), 32'd1);
    cyc(); flush = 0; ex_bubble(); settle();
    chk("flush_cleared", 32'(stall_o[1]), 32'd0);
    cyc();

    // hold freezes the delay line and the counter
    do_reset();
    ex_load(5'd9); id_read0(5'd9);
    cyc(); ex_bubble(); hold = 1; settle();
    chk("hold_stall", 32'(stall_o[1]), 32'd1);
    cyc(); cyc(); settle();
    chk("hold_stall_kept", 32'(stall_o[1]), 32'd1);
    chk("hold_count_frozen", 32'(cnt_o[1]), 32'd1);
    hold = 0;
    cyc(); cyc(); settle();
    chk("hold_release_done", 32'(stall_o[1]), 32'd0);
    chk("hold_count_final", 32'(cnt_o[1]), 32'd3);
    cyc();

    // reset mid-hazard drops pending loads
    do_reset();
    ex_load(5'd9); id_read0(5'd9);
    cyc(); ex_bubble(); rst = 1;
    cyc(); rst = 0; settle();
    chk("rst_mid_drop", 32'(stall_o[1]), 32'd0);
    // load to x0 is never a hazard
    ex_load(5'd0); id_read0(5'd0); settle();
    chk("load_x0", 32'(stall_o[1]), 32'd0);
    cyc();

    // stall-only mode
    do_reset();
    id_ex_rd = 5'd3; id_ex_RegWrite = 1; id_rs = {5'd3, 5'd0}; id_rs_used = 2'b10; settle();
    chk("nf_raw_ex", 32'(stall_o[2]), 32'd1);
    chk("nf_forward_zero", 32'(fwd_o[2]), 32'h0);
    chk("fw_no_raw_stall", 32'(stall_o[0]), 32'd0);
    cyc(); id_rs_used = 2'b00; settle();
    chk("nf_unused", 32'(stall_o[2]), 32'd0);
    cyc(); id_rs_used = 2'b10; id_ex_RegWrite = 0; ex_mem_rd = 5'd3; ex_mem_RegWrite = 1; settle();
    chk("nf_raw_mem", 32'(stall_o[2]), 32'd1);
    cyc(); ex_mem_RegWrite = 0; mem_wb_rd = 5'd3; mem_wb_RegWrite = 1; settle();
    chk("nf_wb_ok", 32'(stall_o[2]), 32'd0);
    cyc();

    // saturation
    do_reset();
    id_ex_rd = 5'd3; id_ex_RegWrite = 1; id_rs = {5'd3, 5'd0}; id_rs_used = 2'b10;
    repeat (65540) cyc();
    settle();
    chk("nf_saturate", 32'(cnt_o[2]), 32'h0000FFFF);
    idle();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
